// File: rtl/retire_trace_pkg.sv
// ---------------------------------------------------------------------------
// retire_trace_pkg
// Shared types for the retire trace buffer: serializer state encoding, the
// captured retire record, the header sync byte and a header builder.
// No ports (package).
// ---------------------------------------------------------------------------
package retire_trace_pkg;

    localparam logic [7:0] TRACE_SYNC = 8'hA5;
    localparam int         SEQ_W      = 18;

    // Serializer state table
    //   state      | meaning
    //   ST_IDLE    | no record loaded, tvalid low
    //   ST_HDR     | presenting header word
    //   ST_PC      | presenting PC word
    //   ST_INSTR   | presenting instruction word
    //   ST_RDATA   | presenting register write data (last for non-stores)
    //   ST_MADDR   | presenting store address
    //   ST_MDATA   | presenting store data (last for stores)
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR,
        ST_PC,
        ST_INSTR,
        ST_RDATA,
        ST_MADDR,
        ST_MDATA
    } trace_state_t;

    typedef struct packed {
        logic [31:0]      pc;
        logic [31:0]      instr;
        logic [4:0]       reg_addr;
        logic [31:0]      reg_data;
        logic [31:0]      mem_addr;
        logic [31:0]      mem_data;
        logic             mem_wrt;
        logic [SEQ_W-1:0] seq;
    } trace_rec_t;

    // Header layout: sync[31:24] | mem_wrt[23] | reg_addr[22:18] | seq[17:0]
    function automatic logic [31:0] trace_hdr(input trace_rec_t rec);
        return {TRACE_SYNC, rec.mem_wrt, rec.reg_addr, rec.seq};
    endfunction

endpackage

// File: rtl/trace_fifo.sv
// ---------------------------------------------------------------------------
// trace_fifo
// Synchronous FIFO of retire records, DEPTH entries (power of two).
// Ports:
//   i_clk, i_rst       clock, synchronous active-high reset
//   i_push, i_wdata    write strobe and record; ignored when full
//   i_pop              read strobe; ignored when empty
//   o_rdata            head record (valid when !o_empty)
//   o_full, o_empty    occupancy flags
//   o_count            current number of stored records
// ---------------------------------------------------------------------------
module trace_fifo
    import retire_trace_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_push,
    input  trace_rec_t                 i_wdata,
    input  logic                       i_pop,
    output trace_rec_t                 o_rdata,
    output logic                       o_full,
    output logic                       o_empty,
    output logic [$clog2(DEPTH):0]     o_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    trace_rec_t     r_mem [DEPTH];
    logic [AW-1:0]  r_wr_ptr;
    logic [AW-1:0]  r_rd_ptr;
    logic [CW-1:0]  r_count;

    logic           w_do_push;
    logic           w_do_pop;

    assign o_full    = (r_count == CW'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_rdata   = r_mem[r_rd_ptr];

    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;

    // Storage is not reset; only the pointers define what is valid.
    always_ff @(posedge i_clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/retire_trace_buffer.sv
// ---------------------------------------------------------------------------
// retire_trace_buffer
// Captures retire records from the core into a FIFO and serializes each
// record as a stream of 32-bit trace words (valid/ready handshake).
// Ports:
//   clk_i, rst_i                  clock, synchronous active-high reset
//   enable_i, update_i            capture enable and retire strobe
//   pc_i, instr_i, reg_addr_i,
//   reg_data_i, mem_addr_i,
//   mem_data_i, mem_wrt_i         retire record fields
//   tvalid_o, tready_i,
//   tdata_o, tlast_o              trace word stream
//   retired_cnt_o                 records captured (wraps)
//   drop_cnt_o                    records dropped on full FIFO (saturates)
//   overflow_o                    sticky drop flag
//   clear_i                       clears the three status outputs
// Only XLEN = 32 is supported.
// ---------------------------------------------------------------------------
module retire_trace_buffer
    import retire_trace_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int DEPTH = 8
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            enable_i,
    input  logic            update_i,
    input  logic [XLEN-1:0] pc_i,
    input  logic [XLEN-1:0] instr_i,
    input  logic [4:0]      reg_addr_i,
    input  logic [XLEN-1:0] reg_data_i,
    input  logic [XLEN-1:0] mem_addr_i,
    input  logic [XLEN-1:0] mem_data_i,
    input  logic            mem_wrt_i,
    output logic            tvalid_o,
    input  logic            tready_i,
    output logic [31:0]     tdata_o,
    output logic            tlast_o,
    output logic [31:0]     retired_cnt_o,
    output logic [15:0]     drop_cnt_o,
    output logic            overflow_o,
    input  logic            clear_i
);

    localparam int CW = $clog2(DEPTH) + 1;

    trace_state_t   r_state;
    trace_rec_t     r_rec;
    logic           r_tvalid;
    logic [31:0]    r_tdata;
    logic           r_tlast;
    logic [31:0]    r_retired_cnt;
    logic [15:0]    r_drop_cnt;
    logic           r_overflow;

    trace_rec_t     w_new_rec;
    trace_rec_t     w_head;
    logic           w_full;
    logic           w_empty;
    logic [CW-1:0]  w_count;
    logic           w_capture;
    logic           w_push;
    logic           w_drop;
    logic           w_accept;
    logic           w_last_acc;
    logic           w_pop;

    always_comb begin
        w_new_rec          = '0;
        w_new_rec.pc       = pc_i;
        w_new_rec.instr    = instr_i;
        w_new_rec.reg_addr = reg_addr_i;
        w_new_rec.reg_data = reg_data_i;
        w_new_rec.mem_addr = mem_addr_i;
        w_new_rec.mem_data = mem_data_i;
        w_new_rec.mem_wrt  = mem_wrt_i;
        w_new_rec.seq      = r_retired_cnt[SEQ_W-1:0];
    end

    // Space is judged on the occupancy before this edge, so a pop on the
    // same edge never makes room for a push into a full FIFO.
    assign w_capture  = enable_i && update_i;
    assign w_push     = w_capture && !w_full;
    assign w_drop     = w_capture && (w_count == CW'(DEPTH));

    assign w_accept   = r_tvalid && tready_i;
    assign w_last_acc = w_accept && r_tlast;
    assign w_pop      = !w_empty && ((r_state == ST_IDLE) || w_last_acc);

    trace_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .i_clk   (clk_i),
        .i_rst   (rst_i),
        .i_push  (w_push),
        .i_wdata (w_new_rec),
        .i_pop   (w_pop),
        .o_rdata (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    // Serializer: outputs are registered and loaded together with the state
    // so the word on tdata_o always belongs to the state being presented.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state  <= ST_IDLE;
            r_rec    <= '0;
            r_tvalid <= 1'b0;
            r_tdata  <= '0;
            r_tlast  <= 1'b0;
        end else if (w_pop) begin
            // Either leaving IDLE or chaining straight into the next record
            r_rec    <= w_head;
            r_state  <= ST_HDR;
            r_tvalid <= 1'b1;
            r_tdata  <= trace_hdr(w_head);
            r_tlast  <= 1'b0;
        end else if (w_last_acc) begin
            r_state  <= ST_IDLE;
            r_tvalid <= 1'b0;
            r_tdata  <= '0;
            r_tlast  <= 1'b0;
        end else if (w_accept) begin
            case (r_state)
                ST_HDR: begin
                    r_state <= ST_PC;
                    r_tdata <= r_rec.pc;
                end
                ST_PC: begin
                    r_state <= ST_INSTR;
                    r_tdata <= r_rec.instr;
                end
                ST_INSTR: begin
                    r_state <= ST_RDATA;
                    r_tdata <= r_rec.reg_data;
                    r_tlast <= !r_rec.mem_wrt;
                end
                ST_RDATA: begin
                    // Non-last RDATA implies a store record
                    r_state <= ST_MADDR;
                    r_tdata <= r_rec.mem_addr;
                    r_tlast <= 1'b0;
                end
                ST_MADDR: begin
                    r_state <= ST_MDATA;
                    r_tdata <= r_rec.mem_data;
                    r_tlast <= 1'b1;
                end
                default: begin
                    r_state  <= ST_IDLE;
                    r_tvalid <= 1'b0;
                    r_tdata  <= '0;
                    r_tlast  <= 1'b0;
                end
            endcase
        end else if (r_state == ST_HDR) begin
            // Stalled header: re-derive from the held record (same value)
            r_tdata <= trace_hdr(r_rec);
        end
    end

    // Status counters; clear wins over any increment on the same edge.
    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            r_retired_cnt <= '0;
            r_drop_cnt    <= '0;
            r_overflow    <= 1'b0;
        end else begin
            if (w_capture) begin
                r_retired_cnt <= r_retired_cnt + 32'd1;
            end
            if (w_drop) begin
                r_overflow <= 1'b1;
                if (r_drop_cnt != 16'hFFFF) begin
                    r_drop_cnt <= r_drop_cnt + 16'd1;
                end
            end
        end
    end

    assign tvalid_o      = r_tvalid;
    assign tdata_o       = r_tdata;
    assign tlast_o       = r_tlast;
    assign retired_cnt_o = r_retired_cnt;
    assign drop_cnt_o    = r_drop_cnt;
    assign overflow_o    = r_overflow;

endmodule

// File: tb/tb_retire_trace_buffer.sv
// ---------------------------------------------------------------------------
// tb_retire_trace_buffer
// Directed bench: expected trace words are queued when a record is driven and
// compared in order as the DUT hands words over.
// ---------------------------------------------------------------------------
module tb_retire_trace_buffer;

    logic        clk_i = 1'b0;
    logic        rst_i, enable_i, update_i, mem_wrt_i, tready_i, clear_i;
    logic [31:0] pc_i, instr_i, reg_data_i, mem_addr_i, mem_data_i;
    logic [4:0]  reg_addr_i;
    logic        tvalid_o, tlast_o, overflow_o;
    logic [31:0] tdata_o, retired_cnt_o;
    logic [15:0] drop_cnt_o;

    int          n_vec = 0;
    int          n_err = 0;
    logic [32:0] q[$];
    logic [32:0] w_exp;
    logic [31:0] m_seq;

    always #5 clk_i = ~clk_i;

    retire_trace_buffer #(.XLEN(32), .DEPTH(8)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .enable_i(enable_i), .update_i(update_i),
        .pc_i(pc_i), .instr_i(instr_i), .reg_addr_i(reg_addr_i),
        .reg_data_i(reg_data_i), .mem_addr_i(mem_addr_i), .mem_data_i(mem_data_i),
        .mem_wrt_i(mem_wrt_i), .tvalid_o(tvalid_o), .tready_i(tready_i),
        .tdata_o(tdata_o), .tlast_o(tlast_o), .retired_cnt_o(retired_cnt_o),
        .drop_cnt_o(drop_cnt_o), .overflow_o(overflow_o), .clear_i(clear_i)
    );

    task automatic check(input string tag, input logic [32:0] obs, input logic [32:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Words are handed over at the next rising edge; inputs change only
    // just after rising edges, so the falling edge sees them settled.
    always @(negedge clk_i) begin
        if (!rst_i && tvalid_o && tready_i) begin
            if (q.size() == 0) begin
                n_vec++;
                n_err++;
                $error("FAIL sb_extra observed=%h expected=none", {tlast_o, tdata_o});
            end else begin
                w_exp = q.pop_front();
                check("sb_word", {tlast_o, tdata_o}, w_exp);
            end
        end
    end

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic send(input logic [31:0] pc, input logic [31:0] ins,
                        input logic [4:0] rd, input logic [31:0] rdat,
                        input logic [31:0] ma, input logic [31:0] md,
                        input logic wrt, input logic keep);
        logic [31:0] hdr;
        pc_i = pc; instr_i = ins; reg_addr_i = rd; reg_data_i = rdat;
        mem_addr_i = ma; mem_data_i = md; mem_wrt_i = wrt;
        update_i = 1'b1;
        if (enable_i) begin
            if (keep) begin
                hdr = {8'hA5, wrt, rd, m_seq[17:0]};
                q.push_back({1'b0, hdr});
                q.push_back({1'b0, pc});
                q.push_back({1'b0, ins});
                q.push_back({!wrt, rdat});
                if (wrt) begin
                    q.push_back({1'b0, ma});
                    q.push_back({1'b1, md});
                end
            end
            m_seq = m_seq + 32'd1;
        end
        step();
        update_i = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int budget);
        for (int i = 0; i < budget; i++) begin
            if (q.size() == 0 && !tvalid_o) break;
            step();
        end
        check(tag, {32'd0, (q.size() == 0) && !tvalid_o}, 33'd1);
    endtask

    initial begin
        rst_i = 1'b1; enable_i = 1'b1; update_i = 1'b0; tready_i = 1'b1;
        clear_i = 1'b0; mem_wrt_i = 1'b0; pc_i = '0; instr_i = '0;
        reg_addr_i = '0; reg_data_i = '0; mem_addr_i = '0; mem_data_i = '0;
        m_seq = '0;
        step();
        step();
        rst_i = 1'b0;

        check("rst_tvalid", {32'd0, tvalid_o}, 33'd0);
        check("rst_tdata", {1'b0, tdata_o}, 33'd0);
        check("rst_tlast", {32'd0, tlast_o}, 33'd0);
        check("rst_retired", {1'b0, retired_cnt_o}, 33'd0);
        check("rst_drop", {17'd0, drop_cnt_o}, 33'd0);
        check("rst_ovf", {32'd0, overflow_o}, 33'd0);

        // Single ALU record: latency and back-to-back words
        send(32'h100, 32'h0050_0093, 5'd1, 32'h5, 32'h0, 32'h0, 1'b0, 1'b1);
        check("lat_edge_n", {32'd0, tvalid_o}, 33'd0);
        step();
        check("lat_hdr_valid", {32'd0, tvalid_o}, 33'd1);
        check("lat_hdr_word", {1'b0, tdata_o}, {1'b0, 32'hA504_0000});
        for (int i = 0; i < 3; i++) begin
            step();
            check("alu_contig", {32'd0, tvalid_o}, 33'd1);
        end
        step();
        check("alu_done", {32'd0, tvalid_o}, 33'd0);

        // Store record: six words, tlast only on store data
        send(32'h104, 32'h00A1_2023, 5'd0, 32'h0, 32'h2000, 32'hDEAD_BEEF, 1'b1, 1'b1);
        wait_idle("store_drain", 20);

        // Stall on the PC word for 10 cycles
        send(32'h108, 32'h0011_2223, 5'd3, 32'h33, 32'h3000, 32'hCAFE_F00D, 1'b1, 1'b1);
        step();
        step();
        tready_i = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            check("stall_hold", {tlast_o, tdata_o}, {1'b0, 32'h108});
        end
        check("stall_valid", {32'd0, tvalid_o}, 33'd1);
        tready_i = 1'b1;
        wait_idle("stall_drain", 20);

        // enable_i = 0 ignores the strobe
        enable_i = 1'b0;
        send(32'h10C, 32'h1, 5'd4, 32'h4, 32'h0, 32'h0, 1'b0, 1'b1);
        step();
        step();
        check("dis_retired", {1'b0, retired_cnt_o}, {1'b0, m_seq});
        check("dis_tvalid", {32'd0, tvalid_o}, 33'd0);
        enable_i = 1'b1;

        // Overflow: serializer holds one stalled record, counters cleared,
        // then 10 updates fill the 8-entry FIFO and drop two.
        tready_i = 1'b0;
        send(32'h200, 32'h2, 5'd5, 32'h55, 32'h0, 32'h0, 1'b0, 1'b1);
        step();
        step();
        clear_i = 1'b1;
        step();
        clear_i = 1'b0;
        m_seq = '0;
        check("clr_retired", {1'b0, retired_cnt_o}, 33'd0);
        for (int i = 0; i < 10; i++) begin
            send(32'h1000 + 32'(i * 4), 32'h100 + 32'(i), 5'(i + 1), 32'(i),
                 32'h0, 32'h0, 1'b0, (i < 8));
        end
        check("ovf_retired", {1'b0, retired_cnt_o}, 33'd10);
        check("ovf_drop", {17'd0, drop_cnt_o}, 33'd2);
        check("ovf_flag", {32'd0, overflow_o}, 33'd1);
        tready_i = 1'b1;
        for (int i = 0; i < 36; i++) begin
            check("b2b_valid", {32'd0, tvalid_o}, 33'd1);
            step();
        end
        check("b2b_done", {32'd0, tvalid_o}, 33'd0);
        check("b2b_sb_empty", {32'd0, q.size() == 0}, 33'd1);

        // clear_i with update_i on the same edge
        check("pre_clr_retired", {1'b0, retired_cnt_o}, 33'd10);
        clear_i = 1'b1;
        send(32'h300, 32'h3, 5'd6, 32'h66, 32'h0, 32'h0, 1'b0, 1'b1);
        clear_i = 1'b0;
        m_seq = '0;
        check("clr_upd_retired", {1'b0, retired_cnt_o}, 33'd0);
        check("clr_upd_drop", {17'd0, drop_cnt_o}, 33'd0);
        check("clr_upd_ovf", {32'd0, overflow_o}, 33'd0);
        wait_idle("clr_upd_drain", 20);

        // Reset while the PC word is presented
        tready_i = 1'b0;
        send(32'h400, 32'h4, 5'd7, 32'h77, 32'h0, 32'h0, 1'b0, 1'b1);
        step();
        tready_i = 1'b1;
        step();
        tready_i = 1'b0;
        check("mid_pc_word", {tlast_o, tdata_o}, {1'b0, 32'h400});
        rst_i = 1'b1;
        update_i = 1'b1;
        step();
        rst_i = 1'b0;
        update_i = 1'b0;
        q.delete();
        m_seq = '0;
        check("mid_rst_tvalid", {32'd0, tvalid_o}, 33'd0);
        check("mid_rst_tdata", {1'b0, tdata_o}, 33'd0);
        check("mid_rst_tlast", {32'd0, tlast_o}, 33'd0);
        check("mid_rst_retired", {1'b0, retired_cnt_o}, 33'd0);
        check("mid_rst_drop", {17'd0, drop_cnt_o}, 33'd0);
        check("mid_rst_ovf", {32'd0, overflow_o}, 33'd0);
        step();
        check("rst_upd_ignored", {32'd0, tvalid_o}, 33'd0);
        tready_i = 1'b1;
        send(32'h500, 32'h5, 5'd8, 32'h88, 32'h0, 32'h0, 1'b0, 1'b1);
        wait_idle("post_rst_drain", 20);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
